// File: rtl/capp_pkg.sv
// Shared definitions for the content-addressable tag array and the blocks that read it.
package capp_pkg;

   localparam int DEF_NUM_CELLS = 100;

   typedef logic [$clog2(DEF_NUM_CELLS)-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EMIT,
      FIN
   } state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the first set bit and an any-set flag.
module lsb_prio_enc
   import capp_pkg::*;
#(
   parameter int NUM_CELLS = DEF_NUM_CELLS,
   parameter int ADDR_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
   input  logic [NUM_CELLS-1:0] vec,
   output logic [ADDR_W-1:0]    idx,
   output logic                 any
);

   // Walking from the top down lets the lowest set bit overwrite last.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (vec[i]) idx = ADDR_W'(i);
      end
   end

endmodule

// File: rtl/tag_responder_iter.sv
// Snapshots the tag vector and hands out responder addresses one by one, lowest first,
// pulsing a one-hot clear back to the tag array for each accepted address.
module tag_responder_iter
   import capp_pkg::*;
#(
   parameter int NUM_CELLS = DEF_NUM_CELLS,
   parameter int ADDR_W    = $clog2(NUM_CELLS),
   parameter int CNT_W     = $clog2(NUM_CELLS + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_CELLS-1:0] tag_wires,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ADDR_W-1:0]    resp_addr,
   output logic [NUM_CELLS-1:0] clear_lines,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     resp_count
);

   state_t                 state, state_n;
   logic [NUM_CELLS-1:0]   pending, pending_n;
   logic [NUM_CELLS-1:0]   clear_n;
   logic [ADDR_W-1:0]      addr_n;
   logic [CNT_W-1:0]       count_n;
   logic [ADDR_W-1:0]      enc_idx;
   logic                   enc_any;

   lsb_prio_enc #(
      .NUM_CELLS (NUM_CELLS),
      .ADDR_W    (ADDR_W)
   ) u_enc (
      .vec (pending),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign resp_valid = (state == EMIT);
   assign busy       = (state != IDLE);
   // An abort landing in FIN suppresses the pulse as well.
   assign done       = (state == FIN) && !abort;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         pending     <= '0;
         resp_addr   <= '0;
         clear_lines <= '0;
         resp_count  <= '0;
      end else begin
         state       <= state_n;
         pending     <= pending_n;
         resp_addr   <= addr_n;
         clear_lines <= clear_n;
         resp_count  <= count_n;
      end
   end

   always_comb begin
      state_n   = state;
      pending_n = pending;
      addr_n    = resp_addr;
      clear_n   = '0;
      count_n   = resp_count;
      if (state != IDLE && abort) begin
         state_n   = IDLE;
         pending_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  pending_n = tag_wires;
                  count_n   = '0;
                  state_n   = SCAN;
               end
            end
            SCAN: begin
               if (!enc_any) begin
                  state_n = FIN;
               end else begin
                  addr_n  = enc_idx;
                  state_n = EMIT;
               end
            end
            EMIT: begin
               if (resp_ready) begin
                  pending_n[resp_addr] = 1'b0;
                  clear_n[resp_addr]   = 1'b1;
                  count_n              = resp_count + CNT_W'(1);
                  state_n              = SCAN;
               end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tag_responder_iter.sv
// Bench for tag_responder_iter: directed scenarios with literal checks plus random traffic
// compared every cycle against a queue-based reference model.
module tb_tag_responder_iter;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [N-1:0]  tag_wires = '0;
   logic          resp_ready = 1'b0;
   logic          resp_valid;
   logic [AW-1:0] resp_addr;
   logic [N-1:0]  clear_lines;
   logic          busy;
   logic          done;
   logic [CW-1:0] resp_count;

   tag_responder_iter #(.NUM_CELLS(N)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .abort       (abort),
      .tag_wires   (tag_wires),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_addr   (resp_addr),
      .clear_lines (clear_lines),
      .busy        (busy),
      .done        (done),
      .resp_count  (resp_count)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is the list of set snapshot bits, handed out with one
   // scan cycle before each address and before the final done.
   int           q[$];
   bit           m_busy, m_show, m_fin;
   int           m_cnt;
   logic [N-1:0] m_clr;
   bit           model_live = 0;

   always @(posedge CLK) begin
      m_clr = '0;
      if (RST) begin
         m_busy = 0; m_show = 0; m_fin = 0; m_cnt = 0; q.delete();
      end else if (!m_busy) begin
         if (start && !abort) begin
            q.delete();
            for (int i = 0; i < N; i++) if (tag_wires[i]) q.push_back(i);
            m_cnt = 0; m_busy = 1; m_show = 0; m_fin = 0;
         end
      end else if (abort) begin
         m_busy = 0; m_show = 0; m_fin = 0; q.delete();
      end else if (m_fin) begin
         m_busy = 0; m_fin = 0;
      end else if (m_show) begin
         if (resp_ready) begin
            m_clr = N'(1) << q[0];
            void'(q.pop_front());
            m_cnt++;
            m_show = 0;
         end
      end else if (q.size() == 0) begin
         m_fin = 1;
      end else begin
         m_show = 1;
      end
      model_live = 1;
   end

   always @(negedge CLK) begin
      #2;
      if (model_live) begin
         chk("busy", busy, m_busy);
         chk("resp_valid", resp_valid, m_show);
         if (m_show) chk("resp_addr", resp_addr, q[0]);
         chk("done", done, m_fin && !abort);
         chk("clear_lines", clear_lines, m_clr);
         chk("resp_count", resp_count, m_cnt);
      end
   end

   // Inputs change on the falling edge; literal checks follow the model compare.
   task automatic tick(input logic r, input logic st, input logic ab, input logic rdy,
                       input logic [N-1:0] tw);
      @(negedge CLK);
      RST = r; start = st; abort = ab; resp_ready = rdy; tag_wires = tw;
      #3;
   endtask

   initial begin
      int k;
      bit seen;
      tick(1, 0, 0, 0, '0);
      tick(1, 0, 0, 0, '0);
      tick(0, 0, 0, 0, '0);
      chk("reset_busy", busy, 0);
      chk("reset_valid", resp_valid, 0);
      chk("reset_addr", resp_addr, 0);
      chk("reset_count", resp_count, 0);
      chk("reset_clear", clear_lines, 0);

      // Three responders, ready held high.
      tick(0, 1, 0, 1, 8'b1010_0100);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c1_valid", resp_valid, 0);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c2_valid", resp_valid, 1); chk("t1_c2_addr", resp_addr, 2);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c3_clr", clear_lines, 8'h04);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c4_addr", resp_addr, 5);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c5_clr", clear_lines, 8'h20);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c6_addr", resp_addr, 7);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c7_clr", clear_lines, 8'h80);
      tick(0, 0, 0, 1, 8'b1010_0100);
      chk("t1_c8_done", done, 1); chk("t1_c8_count", resp_count, 3);
      tick(0, 0, 0, 1, '0);
      chk("t1_idle", busy, 0);

      // No tags at all.
      tick(0, 1, 0, 1, '0);
      tick(0, 0, 0, 1, '0);
      tick(0, 0, 0, 1, '0);
      chk("t2_done", done, 1); chk("t2_count", resp_count, 0); chk("t2_valid", resp_valid, 0);

      // Backpressure holds address 0.
      tick(0, 1, 0, 0, 8'h81);
      tick(0, 0, 0, 0, 8'h81);
      for (int c = 2; c <= 5; c++) begin
         tick(0, 0, 0, 0, 8'h81);
         chk("t3_hold_valid", resp_valid, 1); chk("t3_hold_addr", resp_addr, 0);
         chk("t3_hold_clr", clear_lines, 0);
      end
      tick(0, 0, 0, 1, 8'h81);
      tick(0, 0, 0, 1, 8'h81);
      chk("t3_clr0", clear_lines, 8'h01);
      tick(0, 0, 0, 1, 8'h81);
      chk("t3_addr7", resp_addr, 7);
      tick(0, 0, 0, 1, 8'h81);
      tick(0, 0, 0, 1, 8'h81);
      chk("t3_done", done, 1); chk("t3_count", resp_count, 2);
      tick(0, 0, 0, 1, '0);

      // Frozen snapshot and ignored restart.
      tick(0, 1, 0, 1, 8'hFF);
      k = 0; seen = 0;
      while (k < 60 && !seen) begin
         tick(0, (k == 5), 0, 1'($urandom_range(0, 1)), '0);
         seen = done;
         k++;
      end
      chk("t4_done_seen", seen, 1);
      chk("t4_count", resp_count, 8);
      tick(0, 0, 0, 0, '0);

      // Abort coincident with a handshake on address 3.
      tick(0, 1, 0, 0, 8'h18);
      tick(0, 0, 0, 0, 8'h18);
      tick(0, 0, 0, 0, 8'h18);
      chk("t5_addr", resp_addr, 3);
      tick(0, 0, 1, 1, 8'h18);
      tick(0, 0, 0, 0, 8'h18);
      chk("t5_busy", busy, 0); chk("t5_clr", clear_lines, 0);
      chk("t5_done", done, 0); chk("t5_count", resp_count, 0);

      // Reset mid-EMIT, then a fresh run.
      tick(0, 1, 0, 0, 8'h30);
      tick(0, 0, 0, 0, 8'h30);
      tick(0, 0, 0, 0, 8'h30);
      tick(1, 0, 0, 1, 8'h30);
      tick(0, 0, 0, 0, 8'h02);
      chk("t6_valid", resp_valid, 0); chk("t6_clr", clear_lines, 0); chk("t6_busy", busy, 0);
      tick(0, 1, 0, 1, 8'h02);
      tick(0, 0, 0, 1, 8'h02);
      tick(0, 0, 0, 1, 8'h02);
      chk("t6_addr", resp_addr, 1);

      // Random traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         tick(($urandom_range(0, 149) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)),
              N'($urandom()));
      end
      tick(0, 0, 0, 0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
